// File: rtl/modport_mem_pkg.sv
// rtl/modport_mem_pkg.sv - shared constants, opcodes and FSM encoding for modport_mem
package modport_mem_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH = 4;

   localparam logic OP_WRITE = 1'b1;
   localparam logic OP_READ  = 1'b0;

   typedef enum logic {
      RESET_EXIT = 1'b0,
      ACTIVE     = 1'b1
   } state_t;

   function automatic logic even_parity(input logic [DEF_WIDTH-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/modport_mem_if.sv
// rtl/modport_mem_if.sv - mem_intr valid/ready request bus with master and slave views
interface mem_intr #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 4
) ();
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic                  valid;
   logic [WIDTH-1:0]      rdata;
   logic                  ready;

   modport master (
      output wr_rd, addr, wdata, valid,
      input  rdata, ready
   );

   modport slave (
      input  wr_rd, addr, wdata, valid,
      output rdata, ready
   );

   // design_mp is the name existing memory subsystem code binds to
   modport design_mp (
      input  wr_rd, addr, wdata, valid,
      output rdata, ready
   );
endinterface

// File: rtl/modport_mem_array.sv
// rtl/modport_mem_array.sv - DEPTH x WIDTH register array, async clear, registered read
// Optional parity storage/check under MODPORT_MEM_PARITY_EN.
module modport_mem_array #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
`ifdef MODPORT_MEM_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         mem <= '0;
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

`ifdef MODPORT_MEM_PARITY_EN
   logic [DEPTH-1:0] par;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         par <= '0;
      end else if (we) begin
         par[addr] <= ^wdata;
      end
   end

   // Single-cycle pulse: cleared on any edge that is not a failing read
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= re && ((^mem[addr]) != par[addr]);
      end
   end
`endif

endmodule

// File: rtl/modport_mem.sv
// rtl/modport_mem.sv - single-port memory slave on the mem_intr design_mp handshake
// Build option: MODPORT_MEM_PARITY_EN adds per-word parity and the parity_err output.
module modport_mem
   import modport_mem_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic         clk,
   input  logic         res,
   mem_intr.design_mp   bus
`ifdef MODPORT_MEM_PARITY_EN
   ,
   output logic         parity_err
`endif
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   state_t state_q;
   state_t state_d;
   logic   ready_d;
   logic   ready_q;
   logic   accept;
   logic   we;
   logic   re;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= RESET_EXIT;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RESET_EXIT: state_d = ACTIVE;
         ACTIVE:     state_d = ACTIVE;
         default:    state_d = RESET_EXIT;
      endcase
   end

   // ready is registered, so it rises on the first edge after reset release
   always_comb begin
      ready_d = 1'b0;
      if (state_d == ACTIVE) begin
         ready_d = 1'b1;
      end
   end

   assign bus.ready = ready_q;
   assign accept    = bus.valid && ready_q;
   assign we        = accept && (bus.wr_rd == OP_WRITE);
   assign re        = accept && (bus.wr_rd == OP_READ);

   modport_mem_array #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk        (clk),
      .res        (res),
      .we         (we),
      .re         (re),
      .addr       (bus.addr),
      .wdata      (bus.wdata),
      .rdata      (bus.rdata)
`ifdef MODPORT_MEM_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

endmodule

// File: tb/tb_modport_mem.sv
// tb/tb_modport_mem.sv - scoreboard bench for modport_mem
module tb_modport_mem;

   logic clk;
   logic res;

   mem_intr #(.WIDTH(32), .ADDR_WIDTH(4)) bus ();

`ifdef MODPORT_MEM_PARITY_EN
   logic parity_err;
`endif

   modport_mem #(.WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clk        (clk),
      .res        (res),
      .bus        (bus.design_mp)
`ifdef MODPORT_MEM_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model [16];
   logic [31:0] exp_q [$];
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, cross one edge, then score any read it produced.
   task automatic step(input bit v, input bit wr, input logic [3:0] a, input logic [31:0] d);
      bit acc;
      bus.valid = v;
      bus.wr_rd = wr;
      bus.addr  = a;
      bus.wdata = d;
      acc = v && (bus.ready === 1'b1);
      if (acc && wr) model[a] = d;
      if (acc && !wr) exp_q.push_back(model[a]);
      @(posedge clk);
      #1;
      if (acc && !wr) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            last_rd = exp_q.pop_front();
            chk($sformatf("rdata_a%0d", a), bus.rdata, last_rd);
         end
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 16; i++) model[i] = '0;
      exp_q.delete();
      last_rd = '0;
   endtask

   initial begin
      res       = 1'b0;
      bus.valid = 1'b0;
      bus.wr_rd = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      reset_model();

      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_ready", {31'd0, bus.ready}, 32'd0);
         chk("rst_rdata", bus.rdata, 32'd0);
      end
      res = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", {31'd0, bus.ready}, 32'd1);
      chk("rdata_after_release", bus.rdata, 32'd0);

      step(1'b1, 1'b1, 4'h3, 32'hDEADBEEF);
      step(1'b1, 1'b0, 4'h3, 32'h0);
      chk("deadbeef_direct", bus.rdata, 32'hDEADBEEF);

      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), 32'(i) * 32'h11111111);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i), 32'h0);
      chk("sweep_top", bus.rdata, 32'hFFFFFFFF);

      step(1'b1, 1'b1, 4'h7, 32'h12345678);
      step(1'b1, 1'b0, 4'h7, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
         chk("idle_hold", bus.rdata, 32'h12345678);
      end
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i), 32'h0);

      step(1'b1, 1'b1, 4'h5, 32'hA5A5A5A5);
      bus.valid = 1'b1;
      bus.wr_rd = 1'b0;
      #4;
      res = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
      chk("midrst_rdata", bus.rdata, 32'd0);
      reset_model();
      bus.valid = 1'b0;
      @(posedge clk);
      #1;
      res = 1'b1;
      chk("midrst_ready_hold", {31'd0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_ready_back", {31'd0, bus.ready}, 32'd1);
      step(1'b1, 1'b0, 4'h5, 32'h0);
      chk("midrst_addr5", bus.rdata, 32'd0);

`ifdef MODPORT_MEM_PARITY_EN
      step(1'b1, 1'b1, 4'h2, 32'h0000000F);
      step(1'b1, 1'b0, 4'h2, 32'h0);
      chk("parity_clean", {31'd0, parity_err}, 32'd0);
      force dut.u_array.mem[2] = 32'h0000000E;
      model[2] = 32'h0000000E;
      step(1'b1, 1'b0, 4'h2, 32'h0);
      chk("parity_err_pulse", {31'd0, parity_err}, 32'd1);
      step(1'b0, 1'b0, 4'h0, 32'h0);
      chk("parity_err_drop", {31'd0, parity_err}, 32'd0);
      release dut.u_array.mem[2];
      step(1'b1, 1'b1, 4'h2, 32'h00000007);
      step(1'b1, 1'b0, 4'h2, 32'h0);
      chk("parity_clean2", {31'd0, parity_err}, 32'd0);
`endif

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
